// File: rtl/nv_nvdla_csb_cmd_initiator.sv
//==============================================================================
// nv_nvdla_csb_cmd_initiator
// CSB initiator: issues one register access at a time and returns its result.
// Revision: 1.0
//==============================================================================
`default_nettype none

module nv_nvdla_csb_cmd_initiator #(
  parameter int         TO_W      = 10,
  parameter int         TO_LIMIT  = 1023,
  parameter logic [1:0] REQ_LEVEL = 2'd0,
  parameter logic       SRCPRIV   = 1'b0
) (
  input  logic        nvdla_core_clk,
  input  logic        nvdla_core_rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic        cmd_nposted,
  input  logic [21:0] cmd_addr,
  input  logic [31:0] cmd_wdat,
  input  logic [3:0]  cmd_wrbe,
  output logic        csb_req_pvld,
  input  logic        csb_req_prdy,
  output logic [62:0] csb_req_pd,
  input  logic        csb_resp_valid,
  input  logic [33:0] csb_resp_pd,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_rdat,
  output logic        res_error,
  output logic        res_timeout,
  output logic [7:0]  unexp_rsp_cnt
);

  localparam logic [TO_W:0] LIMIT = TO_LIMIT[TO_W:0];

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT   = 2'd2,
    RESULT = 2'd3
  } state_t;

  state_t          state, state_nxt;
  logic [62:0]     pd;
  logic [TO_W-1:0] timer;
  logic            pd_write, pd_nposted;
  logic            cmd_hs, req_hs, posted, resp_match, timer_hit, res_hs;

  assign pd_write   = pd[54];
  assign pd_nposted = pd[55];
  assign posted     = pd_write & ~pd_nposted;
  assign cmd_hs     = cmd_valid & cmd_ready;
  assign req_hs     = (state == REQ) & csb_req_prdy;
  assign res_hs     = (state == RESULT) & res_ready;
  // Only a response whose type matches the outstanding access completes it.
  assign resp_match = (state == WAIT) & csb_resp_valid & (csb_resp_pd[33] == pd_write);
  assign timer_hit  = ({1'b0, timer} + 1'b1) == LIMIT;

  assign cmd_ready    = (state == IDLE) & ~nvdla_core_rst;
  assign csb_req_pvld = (state == REQ);
  assign csb_req_pd   = pd;
  assign res_valid    = (state == RESULT);

  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) state <= IDLE;
    else                state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cmd_hs) state_nxt = REQ;
      REQ:     if (req_hs) state_nxt = posted ? RESULT : WAIT;
      WAIT:    if (resp_match || timer_hit) state_nxt = RESULT;
      RESULT:  if (res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      pd          <= '0;
      timer       <= '0;
      res_rdat    <= '0;
      res_error   <= 1'b0;
      res_timeout <= 1'b0;
    end else begin
      if (cmd_hs)
        pd <= {REQ_LEVEL, cmd_wrbe, SRCPRIV, cmd_nposted, cmd_write, cmd_wdat, cmd_addr};

      if (req_hs)              timer <= '0;
      else if (state == WAIT)  timer <= timer + 1'b1;

      if (req_hs && posted) begin
        res_rdat    <= '0;
        res_error   <= 1'b0;
        res_timeout <= 1'b0;
      end else if (resp_match) begin
        // A matching response in the timeout cycle takes priority over the timeout.
        res_rdat    <= pd_write ? 32'd0 : csb_resp_pd[31:0];
        res_error   <= csb_resp_pd[32];
        res_timeout <= 1'b0;
      end else if ((state == WAIT) && timer_hit) begin
        res_rdat    <= '0;
        res_error   <= 1'b1;
        res_timeout <= 1'b1;
      end else if (res_hs) begin
        res_rdat    <= '0;
        res_error   <= 1'b0;
        res_timeout <= 1'b0;
      end
    end
  end

  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst)
      unexp_rsp_cnt <= '0;
    else if (csb_resp_valid && !resp_match && (unexp_rsp_cnt != 8'hFF))
      unexp_rsp_cnt <= unexp_rsp_cnt + 8'd1;
  end

endmodule

`default_nettype wire

// File: tb/tb_nv_nvdla_csb_cmd_initiator.sv
//==============================================================================
// tb_nv_nvdla_csb_cmd_initiator
// Randomized transaction-level bench with an outcome model for the CSB initiator.
// Revision: 1.0
//==============================================================================
`default_nettype none

module tb_nv_nvdla_csb_cmd_initiator;

  localparam int TO_LIMIT = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0, cmd_nposted = 1'b0;
  logic [21:0] cmd_addr = '0;
  logic [31:0] cmd_wdat = '0;
  logic [3:0]  cmd_wrbe = '0;
  logic        csb_req_pvld, csb_req_prdy = 1'b0;
  logic [62:0] csb_req_pd;
  logic        csb_resp_valid = 1'b0;
  logic [33:0] csb_resp_pd = '0;
  logic        res_valid, res_ready = 1'b0;
  logic [31:0] res_rdat;
  logic        res_error, res_timeout;
  logic [7:0]  unexp_rsp_cnt;

  int checks = 0;
  int errors = 0;
  int exp_unexp = 0;

  always #5 clk = ~clk;

  nv_nvdla_csb_cmd_initiator #(
    .TO_W(10), .TO_LIMIT(TO_LIMIT), .REQ_LEVEL(2'd0), .SRCPRIV(1'b0)
  ) dut (
    .nvdla_core_clk(clk), .nvdla_core_rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_nposted(cmd_nposted), .cmd_addr(cmd_addr), .cmd_wdat(cmd_wdat),
    .cmd_wrbe(cmd_wrbe), .csb_req_pvld(csb_req_pvld), .csb_req_prdy(csb_req_prdy),
    .csb_req_pd(csb_req_pd), .csb_resp_valid(csb_resp_valid), .csb_resp_pd(csb_resp_pd),
    .res_valid(res_valid), .res_ready(res_ready), .res_rdat(res_rdat),
    .res_error(res_error), .res_timeout(res_timeout), .unexp_rsp_cnt(unexp_rsp_cnt)
  );

  function automatic int sat_inc(input int n);
    return (n < 255) ? n + 1 : 255;
  endfunction

  // One complete access. rlat = WAIT cycle of the matching response (-1: none),
  // bad_at = WAIT cycle of a wrong-type response (-1: none), late = stray
  // response in the first RESULT cycle, rdly = cycles res_ready is held low.
  task automatic run_txn(input logic wr, input logic np, input logic [21:0] addr,
                         input logic [31:0] wd, input logic [3:0] be,
                         input int pdly, input int rlat, input logic rerr,
                         input logic [31:0] rdat, input int bad_at,
                         input logic late, input int rdly);
    logic [62:0] exp_pd;
    logic [31:0] e_rdat;
    logic        e_err, e_to, posted;
    exp_pd = {2'd0, be, 1'b0, np, wr, wd, addr};
    posted = wr & ~np;
    if (posted) begin
      e_rdat = 32'd0; e_err = 1'b0; e_to = 1'b0;
    end else if (rlat >= 0 && rlat < TO_LIMIT) begin
      e_rdat = wr ? 32'd0 : rdat; e_err = rerr; e_to = 1'b0;
    end else begin
      e_rdat = 32'd0; e_err = 1'b1; e_to = 1'b1;
    end

    @(negedge clk);
    checks++;
    if ({cmd_ready, csb_req_pvld, res_valid} !== 3'b100) begin
      errors++;
      $display("FAIL idle_state: got ready/pvld/res_valid=%b expected 100",
               {cmd_ready, csb_req_pvld, res_valid});
    end
    cmd_valid = 1'b1; cmd_write = wr; cmd_nposted = np;
    cmd_addr = addr; cmd_wdat = wd; cmd_wrbe = be;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_wdat = $urandom; cmd_addr = 22'($urandom); cmd_write = ~wr;

    for (int i = 0; i <= pdly; i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if ({csb_req_pvld, cmd_ready, res_valid} !== 3'b100 || csb_req_pd !== exp_pd) begin
        errors++;
        $display("FAIL req_hold[%0d]: pvld/ready/res=%b pd=%h expected 100 pd=%h",
                 i, {csb_req_pvld, cmd_ready, res_valid}, csb_req_pd, exp_pd);
      end
      if (i == pdly) csb_req_prdy = 1'b1;
    end
    @(negedge clk);
    csb_req_prdy = 1'b0;

    if (!posted) begin
      for (int w = 0; w < TO_LIMIT; w++) begin
        checks++;
        if ({res_valid, csb_req_pvld} !== 2'b00) begin
          errors++;
          $display("FAIL wait[%0d]: res_valid/pvld=%b expected 00", w, {res_valid, csb_req_pvld});
        end
        if (w == rlat) begin
          csb_resp_valid = 1'b1; csb_resp_pd = {wr, rerr, rdat};
        end else if (w == bad_at) begin
          csb_resp_valid = 1'b1; csb_resp_pd = {~wr, 1'($urandom), 32'($urandom)};
          exp_unexp = sat_inc(exp_unexp);
        end
        @(negedge clk);
        csb_resp_valid = 1'b0;
        if (w == rlat) break;
      end
    end

    for (int r = 0; r <= rdly; r++) begin
      if (r > 0) @(negedge clk);
      csb_resp_valid = 1'b0;
      checks++;
      if ({res_valid, cmd_ready} !== 2'b10 || res_rdat !== e_rdat ||
          res_error !== e_err || res_timeout !== e_to) begin
        errors++;
        $display("FAIL result[%0d]: valid/ready=%b rdat=%h err=%b to=%b expected 10 rdat=%h err=%b to=%b",
                 r, {res_valid, cmd_ready}, res_rdat, res_error, res_timeout, e_rdat, e_err, e_to);
      end
      if (r == 0 && late) begin
        csb_resp_valid = 1'b1; csb_resp_pd = {wr, 1'b0, 32'($urandom)};
        exp_unexp = sat_inc(exp_unexp);
      end
      if (r == rdly) res_ready = 1'b1;
    end
    @(negedge clk);
    csb_resp_valid = 1'b0; res_ready = 1'b0;
    checks++;
    if ({res_valid, cmd_ready} !== 2'b01 || unexp_rsp_cnt !== 8'(exp_unexp)) begin
      errors++;
      $display("FAIL txn_end: valid/ready=%b unexp=%0d expected 01 unexp=%0d",
               {res_valid, cmd_ready}, unexp_rsp_cnt, exp_unexp);
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({cmd_ready, csb_req_pvld, res_valid, res_error, res_timeout} !== 5'b0 ||
        res_rdat !== 32'd0 || unexp_rsp_cnt !== 8'd0 || csb_req_pd !== 63'd0) begin
      errors++;
      $display("FAIL reset_outputs: ready/pvld/valid/err/to=%b rdat=%h unexp=%0d pd=%h expected all zero",
               {cmd_ready, csb_req_pvld, res_valid, res_error, res_timeout}, res_rdat, unexp_rsp_cnt, csb_req_pd);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    exp_unexp = 0;
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: cmd_ready=%b expected 1", cmd_ready);
    end
  endtask

  task automatic test_directed();
    run_txn(1'b0, 1'b0, 22'h000004, 32'h0, 4'h0, 0, 1, 1'b0, 32'h000000A5, -1, 1'b0, 0);
    run_txn(1'b1, 1'b0, 22'h000010, 32'hDEADBEEF, 4'hF, 0, -1, 1'b0, 32'h0, -1, 1'b0, 1);
    run_txn(1'b1, 1'b1, 22'h000020, 32'h12345678, 4'h3, 5, 2, 1'b0, 32'hFFFFFFFF, -1, 1'b0, 0);
    run_txn(1'b0, 1'b0, 22'h000030, 32'h0, 4'h0, 0, -1, 1'b0, 32'h0, -1, 1'b1, 2);
    // Matching response in the final WAIT cycle beats the timeout.
    run_txn(1'b0, 1'b0, 22'h000040, 32'h0, 4'h0, 1, TO_LIMIT - 1, 1'b1, 32'hCAFEF00D, 3, 1'b0, 0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      logic wr, np;
      int   rlat, bad;
      wr   = 1'($urandom);
      np   = 1'($urandom);
      rlat = $urandom_range(0, TO_LIMIT + 1);
      if (rlat >= TO_LIMIT) rlat = -1;
      bad  = -1;
      if ($urandom_range(0, 2) == 0) begin
        if (rlat < 0)      bad = $urandom_range(0, TO_LIMIT - 1);
        else if (rlat > 0) bad = $urandom_range(0, rlat - 1);
      end
      run_txn(wr, np, 22'($urandom), $urandom, 4'($urandom), $urandom_range(0, 3),
              rlat, 1'($urandom), $urandom, bad, 1'($urandom_range(0, 3) == 0),
              $urandom_range(0, 2));
    end
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 4; n++)
      run_txn(1'b1, 1'b0, 22'(n), $urandom, 4'hF, 0, -1, 1'b0, 32'h0, -1, 1'b0, 0);
  endtask

  task automatic test_unexp_saturate();
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      csb_resp_valid = 1'b1; csb_resp_pd = {1'($urandom), 1'b0, 32'($urandom)};
      exp_unexp = sat_inc(exp_unexp);
    end
    @(negedge clk);
    csb_resp_valid = 1'b0;
    checks++;
    if (unexp_rsp_cnt !== 8'd255 || cmd_ready !== 1'b1 || res_valid !== 1'b0) begin
      errors++;
      $display("FAIL unexp_saturate: cnt=%0d ready=%b res_valid=%b expected 255 1 0",
               unexp_rsp_cnt, cmd_ready, res_valid);
    end
    run_txn(1'b0, 1'b0, 22'h3FFFFF, 32'h0, 4'h0, 0, 0, 1'b0, 32'h5A5A5A5A, -1, 1'b1, 0);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_nposted = 1'b0; cmd_addr = 22'h000008;
    @(negedge clk);
    cmd_valid = 1'b0; csb_req_prdy = 1'b1;
    @(negedge clk);
    csb_req_prdy = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({cmd_ready, csb_req_pvld, res_valid, res_error, res_timeout} !== 5'b0 ||
        res_rdat !== 32'd0 || unexp_rsp_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_mid: ready/pvld/valid/err/to=%b rdat=%h unexp=%0d expected all zero",
               {cmd_ready, csb_req_pvld, res_valid, res_error, res_timeout}, res_rdat, unexp_rsp_cnt);
    end
    exp_unexp = 0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_ready: cmd_ready=%b expected 1", cmd_ready);
    end
    csb_resp_valid = 1'b1; csb_resp_pd = {1'b0, 1'b0, 32'h11111111};
    exp_unexp = sat_inc(exp_unexp);
    @(negedge clk);
    csb_resp_valid = 1'b0;
    run_txn(1'b0, 1'b0, 22'h00000C, 32'h0, 4'h0, 0, 3, 1'b0, 32'h87654321, -1, 1'b0, 0);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_unexp_saturate();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
